imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Parametrised, registered successor to the combinational immediate generator. It decodes every RV32I/RV64I immediate format, plus SHAMT and CSR-zimm, from a 32-bit instruction word. Input and output are valid/ready handshakes, with a 2-entry skid buffer so decode can sit on the ID-stage boundary under back-pressure. It also reports the immediate format and an illegal-opcode flag, and keeps a saturating count of illegal opcodes. Flush support handles branch redirects.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; sets imm_out width and the shamt width (5 bits at 32, 6 bits at 64).
CNT_W, 16, width of the saturating illegal-opcode counter.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
flush  input  1  synchronous; discards all buffered entries.
in_valid  input  1  inst_code is valid.
in_ready  output  1  block can accept; equals "skid entry empty".
inst_code  input  32  instruction word.
out_valid  output  1  imm_out/imm_fmt/imm_illegal are valid.
out_ready  input  1  consumer accepts the output.
imm_out  output  XLEN  extended immediate.
imm_fmt  output  3  format code: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=SHAMT, 7=Z.
imm_illegal  output  1  opcode is unsupported.
illegal_cnt  output  CNT_W  saturating count of accepted illegal opcodes.

Behaviour:
- Reset (async, active-high) clears every register:
  - out_valid=0, imm_out=0, imm_fmt=0, imm_illegal=0, illegal_cnt=0.
  - Skid buffer empty, so in_ready=1 on the first edge after reset deasserts.
- Decode (combinational, applied at accept):
  - opcode = inst[6:0]; sext() = sign-extend to XLEN from the highest immediate bit.
  - 0010011 OP-IMM: if funct3 is 001 or 101, SHAMT = zero-extended inst[24:20] (XLEN=32) or inst[25:20] (XLEN=64). Otherwise I = sext(inst[31:20]).
  - 0000011 LOAD and 1100111 JALR: I = sext(inst[31:20]).
  - 0100011 STORE: S = sext({inst[31:25], inst[11:7]}).
  - 1100011 BRANCH: B = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - 0110111 LUI and 0010111 AUIPC: U = sext({inst[31:12], 12'b0}); sign-extended above bit 31 when XLEN=64.
  - 1101111 JAL: J = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - 1110011 SYSTEM: Z = zero-extended inst[19:15].
  - 0110011 OP: R, imm = 0, not illegal.
  - Any other opcode: imm = 0, fmt = R, imm_illegal = 1.
- Handshake:
  - Accept when in_valid && in_ready; send when out_valid && out_ready.
  - Latency is 1 cycle: an instruction accepted at edge N is visible on the outputs after edge N.
  - Output register loads the decoded word when it is empty or being sent. Otherwise the decoded word goes into the skid entry, and in_ready drops the next cycle.
  - When the output is sent and the skid entry is full, the skid entry moves to the output register and in_ready returns to 1.
  - Strict FIFO order; no entry is ever dropped or duplicated except by flush.
  - Output fields are held stable while out_valid && !out_ready.
- Flush:
  - On the next edge, out_valid=0 and the skid entry is empty.
  - An instruction presented in the flush cycle is discarded and does not update illegal_cnt.
  - in_ready=1 in the cycle after the flush.
- illegal_cnt:
  - Increments by 1 on each accepted illegal instruction.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset.
- Reset asserted mid-transfer clears everything immediately (asynchronously); no partial output.

Test Plan:
- ADDI 0xFFF00093, out_ready=1: one cycle after accept, imm_out=0xFFFFFFFF, imm_fmt=1, imm_illegal=0.
- SRAI 0x41F0D093 -> imm_out=0x0000001F, fmt=6. JAL 0xFFDFF06F -> imm_out=0xFFFFFFFC, fmt=5. BEQ 0xFE000CE3 -> imm_out=0xFFFFFFF8, fmt=3.
- Back-pressure: out_ready=0, present ADDI imm 1, 2, 3 back-to-back.
  - 1 and 2 are accepted; in_ready=0 while 3 is presented.
  - Raise out_ready: outputs are 1, 2, 3 in order, each held stable while stalled.
- Illegal 0x0000007F -> imm_out=0, imm_illegal=1, illegal_cnt=1. With CNT_W=2, 5 illegal words -> illegal_cnt stays at 3.
- Flush with both entries full plus in_valid high: the next cycle has out_valid=0 and in_ready=1, and illegal_cnt is unchanged by the discarded word.
- XLEN=64: LUI 0x800000B7 -> imm_out=0xFFFFFFFF80000000. SRAI with shamt 63 -> imm_out=63. Async reset mid-stall -> all outputs 0 without a clock edge.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//
// Registered RISC-V immediate generator. It decodes the immediate of an
// RV32I/RV64I instruction word (I, S, B, U, J, SHAMT and CSR zimm formats).
// The result is registered behind a valid/ready handshake. A one-entry skid
// register sits in front of the output register, so upstream can stall a
// cycle late without losing a word.
//
// Parameters
//   XLEN   32 or 64. Sets the imm_out width and the shamt width (5 or 6 bits).
//   CNT_W  Width of the saturating illegal-opcode counter.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset; clears every register
//   flush        synchronous; empties output and skid registers, drops input
//   in_valid     inst_code is valid
//   in_ready     block can accept (skid register empty)
//   inst_code    32-bit instruction word
//   out_valid    imm_out / imm_fmt / imm_illegal are valid
//   out_ready    consumer accepts the output
//   imm_out      extended immediate, XLEN bits
//   imm_fmt      0=R 1=I 2=S 3=B 4=U 5=J 6=SHAMT 7=Z
//   imm_illegal  opcode is not supported
//   illegal_cnt  saturating count of accepted illegal opcodes
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_out,
    output logic [2:0]       imm_fmt,
    output logic             imm_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    // Opcodes
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Format codes
    localparam logic [2:0] FMT_R     = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_S     = 3'd2;
    localparam logic [2:0] FMT_B     = 3'd3;
    localparam logic [2:0] FMT_U     = 3'd4;
    localparam logic [2:0] FMT_J     = 3'd5;
    localparam logic [2:0] FMT_SHAMT = 3'd6;
    localparam logic [2:0] FMT_Z     = 3'd7;

    // ------------------------------------------------------------------------
    // Combinational decode of the word currently presented on inst_code.
    // ------------------------------------------------------------------------
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [5:0]      shamt6;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_ill;

    assign opcode = inst_code[6:0];
    assign funct3 = inst_code[14:12];

    always_comb begin
        dec_imm = '0;
        dec_fmt = FMT_R;
        dec_ill = 1'b0;
        // RV64 shifts use a 6-bit shamt. RV32 uses 5 bits, and bit 25 is
        // part of funct7 there.
        shamt6  = (XLEN == 64) ? inst_code[25:20] : {1'b0, inst_code[24:20]};

        // Each signed cast sign-extends from the top bit of the assembled field.
        case (opcode)
            OPC_OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec_imm = XLEN'(shamt6);
                    dec_fmt = FMT_SHAMT;
                end else begin
                    dec_imm = XLEN'($signed(inst_code[31:20]));
                    dec_fmt = FMT_I;
                end
            end
            OPC_LOAD, OPC_JALR: begin
                dec_imm = XLEN'($signed(inst_code[31:20]));
                dec_fmt = FMT_I;
            end
            OPC_STORE: begin
                dec_imm = XLEN'($signed({inst_code[31:25], inst_code[11:7]}));
                dec_fmt = FMT_S;
            end
            OPC_BRANCH: begin
                dec_imm = XLEN'($signed({inst_code[31], inst_code[7],
                                         inst_code[30:25], inst_code[11:8],
                                         1'b0}));
                dec_fmt = FMT_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_imm = XLEN'($signed({inst_code[31:12], 12'b0}));
                dec_fmt = FMT_U;
            end
            OPC_JAL: begin
                dec_imm = XLEN'($signed({inst_code[31], inst_code[19:12],
                                         inst_code[20], inst_code[30:21],
                                         1'b0}));
                dec_fmt = FMT_J;
            end
            OPC_SYSTEM: begin
                dec_imm = XLEN'(inst_code[19:15]);
                dec_fmt = FMT_Z;
            end
            OPC_OP: begin
                dec_imm = '0;
                dec_fmt = FMT_R;
            end
            default: begin
                dec_imm = '0;
                dec_fmt = FMT_R;
                dec_ill = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Handshake: a word moves on a port only in a cycle where valid and ready
    // are both high at the rising edge. valid must not depend on ready. Once
    // out_valid is raised, the output fields hold until out_ready takes them.
    // in_ready depends only on the skid register, so no combinational path
    // runs from out_ready to in_ready. A flush cycle never accepts.
    // ------------------------------------------------------------------------
    logic            skid_valid;
    logic [XLEN-1:0] skid_imm;
    logic [2:0]      skid_fmt;
    logic            skid_ill;
    logic            accept;
    logic            send;
    logic            out_load;

    assign in_ready = ~skid_valid;
    assign accept   = in_valid & in_ready & ~flush;
    assign send     = out_valid & out_ready;
    // The output register can take a new word when it is empty or draining.
    assign out_load = ~out_valid | send;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            imm_out     <= '0;
            imm_fmt     <= FMT_R;
            imm_illegal <= 1'b0;
            skid_valid  <= 1'b0;
            skid_imm    <= '0;
            skid_fmt    <= FMT_R;
            skid_ill    <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_load) begin
            if (skid_valid) begin
                // The skid register holds the older word, so it drains first.
                // accept is low here because in_ready is low.
                out_valid   <= 1'b1;
                imm_out     <= skid_imm;
                imm_fmt     <= skid_fmt;
                imm_illegal <= skid_ill;
                skid_valid  <= 1'b0;
            end else if (accept) begin
                out_valid   <= 1'b1;
                imm_out     <= dec_imm;
                imm_fmt     <= dec_fmt;
                imm_illegal <= dec_ill;
            end else begin
                out_valid   <= 1'b0;
            end
        end else if (accept) begin
            // The output register is stalled, so park the new word.
            skid_valid <= 1'b1;
            skid_imm   <= dec_imm;
            skid_fmt   <= dec_fmt;
            skid_ill   <= dec_ill;
        end
    end

    // ------------------------------------------------------------------------
    // Saturating illegal-opcode counter. Counts at accept, so words dropped by
    // flush are never counted. Only reset clears it.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_cnt <= '0;
        end else if (accept && dec_ill && (illegal_cnt != {CNT_W{1'b1}})) begin
            illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
//
// Directed bench for imm_gen_pipe. dut_a is built with XLEN=32 and CNT_W=2,
// so counter saturation is cheap to reach. dut_b is built with XLEN=64 and
// CNT_W=16. Every expected value is a hand-decoded constant.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- dut_a: XLEN=32, CNT_W=2 ----------------
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_inst;
  logic [31:0] a_imm_out;
  logic [2:0]  a_imm_fmt;
  logic        a_imm_illegal;
  logic [1:0]  a_illegal_cnt;

  imm_gen_pipe #(.XLEN(32), .CNT_W(2)) dut_a (
    .clk         (clk),
    .reset       (reset),
    .flush       (a_flush),
    .in_valid    (a_in_valid),
    .in_ready    (a_in_ready),
    .inst_code   (a_inst),
    .out_valid   (a_out_valid),
    .out_ready   (a_out_ready),
    .imm_out     (a_imm_out),
    .imm_fmt     (a_imm_fmt),
    .imm_illegal (a_imm_illegal),
    .illegal_cnt (a_illegal_cnt)
  );

  // ---------------- dut_b: XLEN=64, CNT_W=16 ----------------
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_inst;
  logic [63:0] b_imm_out;
  logic [2:0]  b_imm_fmt;
  logic        b_imm_illegal;
  logic [15:0] b_illegal_cnt;

  imm_gen_pipe #(.XLEN(64), .CNT_W(16)) dut_b (
    .clk         (clk),
    .reset       (reset),
    .flush       (b_flush),
    .in_valid    (b_in_valid),
    .in_ready    (b_in_ready),
    .inst_code   (b_inst),
    .out_valid   (b_out_valid),
    .out_ready   (b_out_ready),
    .imm_out     (b_imm_out),
    .imm_fmt     (b_imm_fmt),
    .imm_illegal (b_imm_illegal),
    .illegal_cnt (b_illegal_cnt)
  );

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic [31:0] imm, input logic [2:0] fmt,
                         input logic ill);
    check({tag, "_valid"}, 64'(a_out_valid), 64'd1);
    check({tag, "_imm"}, 64'(a_imm_out), 64'(imm));
    check({tag, "_fmt"}, 64'(a_imm_fmt), 64'(fmt));
    check({tag, "_ill"}, 64'(a_imm_illegal), 64'(ill));
  endtask

  task automatic check_b(input string tag, input logic [63:0] imm, input logic [2:0] fmt);
    check({tag, "_valid"}, 64'(b_out_valid), 64'd1);
    check({tag, "_imm"}, b_imm_out, imm);
    check({tag, "_fmt"}, 64'(b_imm_fmt), 64'(fmt));
  endtask

  // ---------------- driver tasks ----------------
  // Present one word for a single cycle. The task returns at the negedge after
  // the accepting posedge, when the decoded word sits in the output register.
  task automatic drive_a(input logic [31:0] inst);
    @(negedge clk);
    a_inst     = inst;
    a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
  endtask

  task automatic drive_b(input logic [31:0] inst);
    @(negedge clk);
    b_inst     = inst;
    b_in_valid = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1; a_inst = 32'h0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1; b_inst = 32'h0;

    #1;
    check("rst_a_valid", 64'(a_out_valid), 64'd0);
    check("rst_a_imm", 64'(a_imm_out), 64'd0);
    check("rst_a_fmt", 64'(a_imm_fmt), 64'd0);
    check("rst_a_ill", 64'(a_imm_illegal), 64'd0);
    check("rst_a_cnt", 64'(a_illegal_cnt), 64'd0);
    check("rst_b_imm", b_imm_out, 64'd0);

    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_a_rdy", 64'(a_in_ready), 64'd1);
    check("rst_b_rdy", 64'(b_in_ready), 64'd1);

    // Single-word decodes, XLEN=32, consumer always ready
    drive_a(32'hFFF00093); check_a("addi_m1", 32'hFFFFFFFF, 3'd1, 1'b0);
    drive_a(32'h41F0D093); check_a("srai31", 32'h0000001F, 3'd6, 1'b0);
    drive_a(32'h43F0D093); check_a("srai_rv32", 32'h0000001F, 3'd6, 1'b0);
    drive_a(32'hFFDFF06F); check_a("jal_m4", 32'hFFFFFFFC, 3'd5, 1'b0);
    drive_a(32'hFE000CE3); check_a("beq_m8", 32'hFFFFFFF8, 3'd3, 1'b0);
    drive_a(32'hFE112E23); check_a("sw_m4", 32'hFFFFFFFC, 3'd2, 1'b0);
    drive_a(32'h12345037); check_a("lui", 32'h12345000, 3'd4, 1'b0);
    drive_a(32'h000AD073); check_a("csr_zimm", 32'h00000015, 3'd7, 1'b0);
    drive_a(32'h002081B3); check_a("add_r", 32'h00000000, 3'd0, 1'b0);
    drive_a(32'h0000007F); check_a("illegal", 32'h00000000, 3'd0, 1'b1);
    check("illegal_cnt1", 64'(a_illegal_cnt), 64'd1);

    // Back-pressure: words 1, 2, 3 presented back to back while stalled
    @(negedge clk);
    check("bp_idle", 64'(a_out_valid), 64'd0);
    a_out_ready = 1'b0;
    a_inst = 32'h00100093; a_in_valid = 1'b1; exp_q.push_back(64'd1);
    @(negedge clk);
    check("bp_rdy_w2", 64'(a_in_ready), 64'd1);
    a_inst = 32'h00200093; exp_q.push_back(64'd2);
    @(negedge clk);
    check("bp_rdy_w3", 64'(a_in_ready), 64'd0);
    check("bp_hold1", 64'(a_imm_out), exp_q[0]);
    a_inst = 32'h00300093;
    @(negedge clk);
    check("bp_rdy_w3b", 64'(a_in_ready), 64'd0);
    check("bp_hold2", 64'(a_imm_out), exp_q[0]);
    check("bp_hold_v", 64'(a_out_valid), 64'd1);
    exp_q.push_back(64'd3);
    a_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) a_in_valid = 1'b0;
      check("bp_drain_v", 64'(a_out_valid), 64'd1);
      check("bp_drain_imm", 64'(a_imm_out), exp_q.pop_front());
      if (k == 1) check("bp_rdy_back", 64'(a_in_ready), 64'd1);
      @(negedge clk);
    end
    check("bp_empty", 64'(a_out_valid), 64'd0);

    // Flush with both registers full and a word (illegal) presented
    a_out_ready = 1'b0;
    a_inst = 32'h00100093; a_in_valid = 1'b1;
    @(negedge clk);
    a_inst = 32'h00200093;
    @(negedge clk);
    check("fl_full_rdy", 64'(a_in_ready), 64'd0);
    check("fl_full_v", 64'(a_out_valid), 64'd1);
    a_inst = 32'h0000007F; a_flush = 1'b1;
    @(negedge clk);
    check("fl_v", 64'(a_out_valid), 64'd0);
    check("fl_rdy", 64'(a_in_ready), 64'd1);
    check("fl_cnt", 64'(a_illegal_cnt), 64'd1);
    // A second flush cycle, now with in_ready high: the word is still dropped
    @(negedge clk);
    a_flush = 1'b0; a_in_valid = 1'b0;
    check("fl2_v", 64'(a_out_valid), 64'd0);
    check("fl2_cnt", 64'(a_illegal_cnt), 64'd1);
    a_out_ready = 1'b1;

    // Counter saturation at 3 (CNT_W=2): four more illegal words
    drive_a(32'h0000007F);
    drive_a(32'h0000007F);
    check("sat_cnt3", 64'(a_illegal_cnt), 64'd3);
    drive_a(32'h0000007F);
    drive_a(32'h0000007F);
    check("sat_hold", 64'(a_illegal_cnt), 64'd3);
    check_a("sat_word", 32'h00000000, 3'd0, 1'b1);

    // XLEN=64 decodes
    drive_b(32'h800000B7); check_b("b_lui", 64'hFFFFFFFF80000000, 3'd4);
    drive_b(32'h43F0D093); check_b("b_srai63", 64'd63, 3'd6);
    drive_b(32'hFFF00093); check_b("b_addi_m1", 64'hFFFFFFFFFFFFFFFF, 3'd1);

    // Async reset while dut_b is stalled with both registers full
    @(negedge clk);
    b_out_ready = 1'b0;
    b_inst = 32'h800000B7; b_in_valid = 1'b1;
    @(negedge clk);
    b_inst = 32'h0000007F;
    @(negedge clk);
    b_in_valid = 1'b0;
    check("ar_pre_rdy", 64'(b_in_ready), 64'd0);
    check("ar_pre_cnt", 64'(b_illegal_cnt), 64'd1);
    check_b("ar_pre", 64'hFFFFFFFF80000000, 3'd4);
    #1 reset = 1'b1;
    #1;
    check("ar_v", 64'(b_out_valid), 64'd0);
    check("ar_imm", b_imm_out, 64'd0);
    check("ar_fmt", 64'(b_imm_fmt), 64'd0);
    check("ar_ill", 64'(b_imm_illegal), 64'd0);
    check("ar_cnt", 64'(b_illegal_cnt), 64'd0);
    check("ar_rdy", 64'(b_in_ready), 64'd1);
    check("ar_a_cnt", 64'(a_illegal_cnt), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
